// File: rtl/toyup_ioport_pkg.sv
// Shared types and helpers for the toyup I/O port bank.
// No logic; imported by toyup_ioport and toyup_io_chan.
package toyup_ioport_pkg;

    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    // Data registers, then STATUS_IN, STATUS_OUT, ERR.
    function automatic int toyup_addr_w(input int nch);
        return $clog2(nch + 3);
    endfunction

endpackage

// File: rtl/toyup_io_chan.sv
// One input + one output channel: strobe sync/edge latch with overrun, output valid/ack FSM with drop.
// Latency: input latched SYNC_STAGES+1 clks after in_stb rises; output valid 1 clk after accepted write.
// Backpressure: none; unread input is overwritten (in_ovr), write into unacked output is dropped (out_drop).
module toyup_io_chan
    import toyup_ioport_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_stb,
    input  logic [W-1:0] in_dat,
    input  logic         rd_clr,
    input  logic         ovr_clr,
    output logic [W-1:0] in_data,
    output logic         in_full,
    output logic         in_ovr,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         out_ack,
    input  logic         drop_clr,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    output logic         out_drop
);

    logic [SYNC_STAGES-1:0] stb_sync;
    logic                   stb_prev;
    logic                   stb_rise;
    out_state_t             state;

    assign stb_rise = stb_sync[SYNC_STAGES-1] & ~stb_prev;
    assign out_vld  = (state == OUT_VALID);

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_sync <= '0;
            stb_prev <= 1'b0;
            in_data  <= '0;
            in_full  <= 1'b0;
            in_ovr   <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], in_stb};
            stb_prev <= stb_sync[SYNC_STAGES-1];
            // A new edge wins over a clearing read: data is replaced and the flag stays up.
            if (stb_rise) begin
                in_data <= in_dat;
                in_full <= 1'b1;
            end else if (rd_clr) begin
                in_full <= 1'b0;
            end
            if (stb_rise && in_full && !rd_clr) begin
                in_ovr <= 1'b1;
            end else if (ovr_clr) begin
                in_ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OUT_IDLE;
            out_dat  <= '0;
            out_drop <= 1'b0;
        end else begin
            case (state)
                OUT_IDLE: begin
                    if (wr_vld) begin
                        out_dat <= wr_dat;
                        state   <= OUT_VALID;
                    end
                end
                OUT_VALID: begin
                    if (wr_vld && out_ack) begin
                        out_dat <= wr_dat;
                    end else if (out_ack) begin
                        state <= OUT_IDLE;
                    end
                end
            endcase
            if (wr_vld && (state == OUT_VALID) && !out_ack) begin
                out_drop <= 1'b1;
            end else if (drop_clr) begin
                out_drop <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/toyup_io_defs.vh
// Register offsets and err-bit packing for the toyup I/O port bank.
// Shared with the CPU-side address decoder.
`ifndef TOYUP_IO_DEFS_VH
`define TOYUP_IO_DEFS_VH

`define TOYUP_REG_DATA_BASE   0
`define TOYUP_REG_STATUS_IN   0
`define TOYUP_REG_STATUS_OUT  1
`define TOYUP_REG_ERR         2

`define TOYUP_ERR_PACK(drop, ovr) {drop, ovr}

`endif

// File: rtl/toyup_ioport.sv
// CPU register bank over NCH input/output channels: address decode, registered read mux, irq.
// Latency: rdata 1 clk after rd_en (held until next rd_en); irq 1 clk after any flag change.
// Backpressure: none toward the CPU; channel-level conflicts are reported through err bits.
`include "toyup_io_defs.vh"
module toyup_ioport
    import toyup_ioport_pkg::*;
#(
    parameter int W           = 8,
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    localparam int ADDR_W     = toyup_addr_w(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata,
    input  logic [NCH*W-1:0]  IPORT,
    input  logic [NCH-1:0]    in_stb,
    output logic [NCH*W-1:0]  OPORT,
    output logic [NCH-1:0]    out_vld,
    input  logic [NCH-1:0]    out_ack,
    output logic              irq
);

    localparam int EW = 2 * NCH;
    localparam logic [ADDR_W-1:0] A_STAT_IN  = ADDR_W'(NCH + `TOYUP_REG_STATUS_IN);
    localparam logic [ADDR_W-1:0] A_STAT_OUT = ADDR_W'(NCH + `TOYUP_REG_STATUS_OUT);
    localparam logic [ADDR_W-1:0] A_ERR      = ADDR_W'(NCH + `TOYUP_REG_ERR);

    logic [W-1:0]   in_data [NCH];
    logic [W-1:0]   out_dat [NCH];
    logic [NCH-1:0] in_full;
    logic [NCH-1:0] in_ovr;
    logic [NCH-1:0] out_drop;
    logic [NCH-1:0] rd_clr;
    logic [NCH-1:0] wr_vld;
    logic [NCH-1:0] ovr_clr;
    logic [NCH-1:0] drop_clr;
    logic [EW-1:0]  err_vec;
    logic [EW-1:0]  err_wclr;
    logic [W-1:0]   rd_mux;

    // The cast truncates out_drop when the bus is narrower than the packed err word.
    assign err_vec  = `TOYUP_ERR_PACK(out_drop, in_ovr);
    assign err_wclr = (wr_en && (addr == A_ERR)) ? EW'(wdata) : '0;
    assign ovr_clr  = err_wclr[NCH-1:0];
    assign drop_clr = err_wclr[EW-1:NCH];

    always_comb begin
        rd_clr = '0;
        wr_vld = '0;
        for (int k = 0; k < NCH; k++) begin
            rd_clr[k] = rd_en && (addr == ADDR_W'(`TOYUP_REG_DATA_BASE + k));
            wr_vld[k] = wr_en && (addr == ADDR_W'(`TOYUP_REG_DATA_BASE + k));
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (addr == ADDR_W'(`TOYUP_REG_DATA_BASE + k)) begin
                rd_mux = in_data[k];
            end
        end
        if (addr == A_STAT_IN) begin
            rd_mux = W'(in_full);
        end else if (addr == A_STAT_OUT) begin
            rd_mux = W'(out_vld);
        end else if (addr == A_ERR) begin
            rd_mux = W'(err_vec);
        end
    end

    always_comb begin
        OPORT = '0;
        for (int k = 0; k < NCH; k++) begin
            OPORT[k*W +: W] = out_dat[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            if (rd_en) begin
                rdata <= rd_mux;
            end
            irq <= (|in_full) | (|in_ovr) | (|out_drop);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        toyup_io_chan #(
            .W           (W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .in_stb   (in_stb[k]),
            .in_dat   (IPORT[k*W +: W]),
            .rd_clr   (rd_clr[k]),
            .ovr_clr  (ovr_clr[k]),
            .in_data  (in_data[k]),
            .in_full  (in_full[k]),
            .in_ovr   (in_ovr[k]),
            .wr_vld   (wr_vld[k]),
            .wr_dat   (wdata),
            .out_ack  (out_ack[k]),
            .drop_clr (drop_clr[k]),
            .out_dat  (out_dat[k]),
            .out_vld  (out_vld[k]),
            .out_drop (out_drop[k])
        );
    end

endmodule
